// File: rtl/wb_ram_param.sv
// Wishbone classic single-beat slave RAM with configurable width, depth and ack latency.
// Byte-lane masked reads and writes, error termination for out-of-range addresses, and cycle abort.
module wb_ram_param #(
  parameter int    DATA_W      = 32,
  parameter int    DEPTH_LOG2  = 12,
  parameter int    LATENCY     = 2,
  parameter string INIT_PREFIX = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] sel,
  input  logic                we,
  input  logic                cyc,
  input  logic                stb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ack,
  output logic                err
);
  localparam int LANES = DATA_W / 8;
  localparam int B     = $clog2(LANES);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              we_reg;
  logic              in_range_reg;
  logic [DATA_W-1:0] rd_buf;
  logic [DATA_W-1:0] mem_rd;

  logic [DEPTH_LOG2-1:0] word;
  logic                  in_range;
  logic                  req;
  logic                  accept;

  assign word     = addr[B +: DEPTH_LOG2];
  assign in_range = ((addr >> (B + DEPTH_LOG2)) == 32'd0);
  assign req      = cyc & stb;
  assign accept   = req && (state_reg == IDLE);

  // One byte-wide array per lane; writes and the read capture both happen on the accepting edge.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] buf_reg;

    always_ff @(posedge clk) begin
      if (accept && in_range && we && sel[gi])
        mem[word] <= wdata[8*gi +: 8];
      if (accept && in_range && !we)
        buf_reg <= sel[gi] ? mem[word] : 8'h00;
    end

    assign rd_buf[8*gi +: 8] = buf_reg;
    assign mem_rd[8*gi +: 8] = sel[gi] ? mem[word] : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      we_reg       <= 1'b0;
      in_range_reg <= 1'b0;
      ack          <= 1'b0;
      err          <= 1'b0;
      rdata        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (req) begin
            we_reg       <= we;
            in_range_reg <= in_range;
            cnt_reg      <= CNT_W'(LATENCY - 1);
            // Single-edge latency terminates on the accepting edge, reading the array directly.
            if (LATENCY == 1) begin
              ack       <= in_range;
              err       <= !in_range;
              if (in_range && !we) rdata <= mem_rd;
              state_reg <= DONE;
            end else begin
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!cyc) begin
            state_reg <= IDLE;
          end else if (cnt_reg == '0) begin
            ack       <= in_range_reg;
            err       <= !in_range_reg;
            if (in_range_reg && !we_reg) rdata <= rd_buf;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          ack       <= 1'b0;
          err       <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
